// File: rtl/mod_mult_pkg.sv
// rtl/mod_mult_pkg.sv - shared mode/state encodings and Booth digit-count helper
package mod_mult_pkg;

  typedef enum logic [1:0] {
    MODE_PLAIN = 2'b00,
    MODE_M1    = 2'b01,
    MODE_P1    = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRECOMP = 3'd1,
    ST_ITER    = 3'd2,
    ST_REDUCE  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // Radix-8 digits needed for an n-bit signed multiplier: ceil((n+1)/3)
  function automatic int calc_k(input int n);
    return (n + 3) / 3;
  endfunction

endpackage

// File: rtl/seq_modulo_booth_multiplier_if.sv
// rtl/seq_modulo_booth_multiplier_if.sv - operand/result handshake bundle
interface seq_modulo_booth_multiplier_if #(parameter int N = 8);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [1:0]     mod_sel;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] P;
  logic           mode_err;

  modport master (
    output in_valid, A, B, mod_sel, out_ready,
    input  in_ready, out_valid, P, mode_err
  );

  modport slave (
    input  in_valid, A, B, mod_sel, out_ready,
    output in_ready, out_valid, P, mode_err
  );

endinterface

// File: rtl/booth_r8_digit_sel.sv
// rtl/booth_r8_digit_sel.sv - radix-8 Booth digit recoding and partial-product select
module booth_r8_digit_sel #(
  parameter int N = 8
) (
  input  logic [3:0]          bits,
  input  logic signed [N-1:0] a,
  input  logic signed [N+1:0] a3,
  output logic signed [N+2:0] pp
);

  logic signed [N+2:0] a1_x;
  logic signed [N+2:0] a2_x;
  logic signed [N+2:0] a3_x;
  logic signed [N+2:0] a4_x;

  assign a1_x = {{3{a[N-1]}}, a};
  assign a2_x = {{2{a[N-1]}}, a, 1'b0};
  assign a3_x = {a3[N+1], a3};
  assign a4_x = {a[N-1], a, 2'b00};

  // bits = {b[3i+2], b[3i+1], b[3i], b[3i-1]}; digit = -4*b3 + 2*b2 + b1 + b0
  always_comb begin
    pp = '0;
    case (bits)
      4'b0001, 4'b0010: pp = a1_x;
      4'b0011, 4'b0100: pp = a2_x;
      4'b0101, 4'b0110: pp = a3_x;
      4'b0111:          pp = a4_x;
      4'b1000:          pp = -a4_x;
      4'b1001, 4'b1010: pp = -a3_x;
      4'b1011, 4'b1100: pp = -a2_x;
      4'b1101, 4'b1110: pp = -a1_x;
      default:          pp = '0;
    endcase
  end

endmodule

// File: rtl/seq_modulo_booth_multiplier.sv
// rtl/seq_modulo_booth_multiplier.sv - sequential radix-8 Booth multiplier with 2^N-1 / 2^N+1 residue modes
module seq_modulo_booth_multiplier
  import mod_mult_pkg::*;
#(
  parameter int N = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  seq_modulo_booth_multiplier_if.slave bus
);

  localparam int K     = calc_k(N);
  localparam int ACC_W = 2 * N + 3;
  localparam int BX_W  = 3 * K + 1;
  localparam int CNT_W = $clog2(K + 1);
  localparam int PP_W  = N + 3;

  localparam logic signed [N+1:0] MOD_M1 = {2'b00, {N{1'b1}}};
  localparam logic signed [N+1:0] MOD_P1 = {2'b01, {(N - 1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic signed [N-1:0]     a_reg;
  logic signed [N+1:0]     a3_reg;
  logic [BX_W-1:0]         b_win;
  mode_t                   mode_reg;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic [2*N-1:0]          p_reg;
  logic                    out_valid_reg;
  logic                    mode_err_reg;

  logic                    accept;
  logic                    last_digit;
  logic signed [PP_W-1:0]  pp;
  logic signed [ACC_W-1:0] pp_shifted;

  logic [2*N-1:0]          prod;
  logic signed [N+1:0]     hi_x;
  logic signed [N+1:0]     lo_x;
  logic signed [N+1:0]     s_m1;
  logic signed [N+1:0]     s_p1;
  logic signed [N+1:0]     r_m1;
  logic signed [N+1:0]     r_p1;
  logic [2*N-1:0]          result;
  logic                    unused_bits;

  assign accept     = bus.in_valid && (state == ST_IDLE);
  assign last_digit = (cnt == CNT_W'(K - 1));

  booth_r8_digit_sel #(.N(N)) u_digit_sel (
    .bits (b_win[3:0]),
    .a    (a_reg),
    .a3   (a3_reg),
    .pp   (pp)
  );

  // Digit i carries weight 8^i; the low-bit window of b_win always holds the current digit
  assign pp_shifted = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp} <<< (3 * cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.in_valid) state_nxt = ST_PRECOMP;
      ST_PRECOMP: state_nxt = ST_ITER;
      ST_ITER:    if (last_digit) state_nxt = ST_REDUCE;
      ST_REDUCE:  state_nxt = ST_HOLD;
      ST_HOLD:    if (bus.out_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      a3_reg        <= '0;
      b_win         <= '0;
      mode_reg      <= MODE_PLAIN;
      acc           <= '0;
      cnt           <= '0;
      p_reg         <= '0;
      out_valid_reg <= 1'b0;
      mode_err_reg  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg    <= bus.A;
            b_win    <= {{(BX_W - N - 1){bus.B[N-1]}}, bus.B, 1'b0};
            mode_reg <= mode_t'(bus.mod_sel);
          end
        end
        ST_PRECOMP: begin
          a3_reg <= {a_reg[N-1], a_reg, 1'b0} + {{2{a_reg[N-1]}}, a_reg};
          acc    <= '0;
          cnt    <= '0;
        end
        ST_ITER: begin
          acc   <= acc + pp_shifted;
          b_win <= {{3{b_win[BX_W-1]}}, b_win[BX_W-1:3]};
          cnt   <= cnt + 1'b1;
        end
        ST_REDUCE: begin
          p_reg         <= result;
          mode_err_reg  <= (mode_reg == MODE_RSVD);
          out_valid_reg <= 1'b1;
        end
        ST_HOLD: begin
          if (bus.out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Split product as hi*2^N + lo; 2^N is +1 mod 2^N-1 and -1 mod 2^N+1, so one fold plus one correction suffices
  always_comb begin
    prod = acc[2*N-1:0];
    hi_x = {{2{prod[2*N-1]}}, prod[2*N-1:N]};
    lo_x = {2'b00, prod[N-1:0]};
    s_m1 = lo_x + hi_x;
    s_p1 = lo_x - hi_x;

    r_m1 = s_m1;
    if (s_m1[N+1])             r_m1 = s_m1 + MOD_M1;
    else if (s_m1 >= MOD_M1)   r_m1 = s_m1 - MOD_M1;

    r_p1 = s_p1;
    if (s_p1[N+1])             r_p1 = s_p1 + MOD_P1;
    else if (s_p1 >= MOD_P1)   r_p1 = s_p1 - MOD_P1;

    case (mode_reg)
      MODE_M1: result = {{N{1'b0}}, r_m1[N-1:0]};
      MODE_P1: result = {{(N - 1){1'b0}}, r_p1[N:0]};
      default: result = prod;
    endcase
  end

  assign unused_bits = ^{acc[ACC_W-1:2*N], r_m1[N+1:N], r_p1[N+1]};

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.P         = p_reg;
  assign bus.mode_err  = mode_err_reg;

endmodule

// File: doc/seq_modulo_booth_multiplier.md
SEQ_MODULO_BOOTH_MULTIPLIER -- requirements
Module: seq_modulo_booth_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, operand width, legal range 4..32.
REQ-002 SHALL have localparam K = ceil((N+1)/3), the number of radix-8 Booth digit iterations.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, operands and mode valid.
REQ-006 SHALL have port in_ready, output, 1 bit, block can accept an operation.
REQ-007 SHALL have port A, input, N bits, signed multiplicand.
REQ-008 SHALL have port B, input, N bits, signed multiplier.
REQ-009 SHALL have port mod_sel, input, 2 bits, mode: 00 plain, 01 mod 2^N-1, 10 mod 2^N+1, 11 reserved.
REQ-010 SHALL have port out_valid, output, 1 bit, result valid.
REQ-011 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-012 SHALL have port P, output, 2N bits, result.
REQ-013 SHALL have port mode_err, output, 1 bit, high with out_valid when the captured mod_sel was 11.

Function
REQ-014 SHALL use FSM states IDLE, PRECOMP, ITER, REDUCE, HOLD.
REQ-015 SHALL drive in_ready high only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-016 SHALL, on acceptance, register A, B and mod_sel, then go to PRECOMP; later input changes have no effect.
REQ-017 SHALL compute and register 3A (N+2-bit signed) in PRECOMP in one cycle, then go to ITER.
REQ-018 SHALL, in ITER, consume one radix-8 Booth digit per cycle, LSB first (digit set -4..+4, B sign-extended, implicit 0 below the LSB), accumulating into a 2N+3-bit signed accumulator; leave ITER after exactly K cycles.
REQ-019 SHALL, in REDUCE, form the result in one cycle and register P, mode_err and out_valid=1, then go to HOLD.
REQ-020 SHALL, for mode 00, set P to the exact signed 2N-bit two's-complement product A*B.
REQ-021 SHALL, for mode 01, set P to the canonical residue of A*B mod (2^N-1), in range 0..2^N-2, zero-extended; the all-ones residue maps to 0.
REQ-022 SHALL, for mode 10, set P to the residue of A*B mod (2^N+1), in range 0..2^N (N+1 bits), zero-extended.
REQ-023 SHALL treat negative products with mathematical modulo (non-negative residue) in modes 01 and 10.
REQ-024 SHALL, for mode 11, produce the mode 00 result with mode_err=1; mode_err=0 otherwise.
REQ-025 SHALL hold P, mode_err and out_valid stable in HOLD until out_ready=1 at an edge; then clear out_valid and return to IDLE.
REQ-026 SHALL give a latency of K+2 rising edges from acceptance to out_valid=1 (N=8: 5).
REQ-027 SHALL allow the next acceptance no earlier than the edge after result consumption; no overlap or pipelining.
REQ-028 SHALL allow out_ready high before out_valid without effect.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously force state=IDLE, in_ready=1, out_valid=0, mode_err=0, P=0 and clear all datapath registers, including mid-ITER or in HOLD.
REQ-030 SHALL discard any in-flight operation on reset and produce no result for it after reset release.

Structure
REQ-031 SHALL put the mode encodings, FSM state encoding and a K-computing function in shared package mod_mult_pkg.
REQ-032 SHALL implement digit recoding and partial-product selection (0, ±A, ±2A, ±3A, ±4A) in sub-module booth_r8_digit_sel.

Verification (N=8)
REQ-033 SHALL cover A=7, B=9, mod_sel=00 -> P=63, out_valid exactly 5 edges after acceptance.
REQ-034 SHALL cover A=-128, B=-128, mod_sel=00 -> P=16384; then A=-128, B=127 -> P=-16256 (0xC080).
REQ-035 SHALL cover mod_sel=01: A=100, B=100 -> P=55; A=15, B=17 -> P=0 (all-ones canonicalised).
REQ-036 SHALL cover mod_sel=10: A=-3, B=5 -> P=242; A=16, B=16 -> P=256.
REQ-037 SHALL cover out_ready low for 10 cycles -> P/out_valid stable, in_ready=0, in_valid pulses ignored; mod_sel=11 -> mode_err=1.
REQ-038 SHALL cover rst_n pulsed low during ITER -> immediate IDLE/zero outputs, no stale result after release, next operation correct.
